// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - producer and register-file write port bundle for the writeback arbiter
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BITS   = 5
);
  logic                  alu_valid;
  logic [SEL_BITS-1:0]   alu_sel;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [SEL_BITS-1:0]   mem_sel;
  logic [2:0]            mem_funct3;
  logic [1:0]            mem_addr_lo;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wEn;
  logic [SEL_BITS-1:0]   write_sel;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  misalign;

  modport master (
    output alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_funct3, mem_addr_lo, mem_rdata,
    input  alu_ready, wEn, write_sel, write_data, misalign
  );

  modport slave (
    input  alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_funct3, mem_addr_lo, mem_rdata,
    output alu_ready, wEn, write_sel, write_data, misalign
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbiter: loads first, ALU results via skid FIFO
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_BITS   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  writeback_arbiter_if.slave  bus
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int CW = IW + 1;

  logic [SEL_BITS-1:0]   q_sel  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [CW-1:0]         count;

  logic [SEL_BITS-1:0]   n_sel  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] n_data [FIFO_DEPTH];
  logic [CW-1:0]         n_count;

  logic [DATA_WIDTH-1:0] shifted, ld_data;
  logic                  ld_mis, ld_write, alu_take, deq, bypass, enq;
  logic                  w_en;
  logic [SEL_BITS-1:0]   w_sel;
  logic [DATA_WIDTH-1:0] w_data;

  assign bus.alu_ready = !reset && (count < CW'(FIFO_DEPTH));

  always_comb begin
    shifted = bus.mem_rdata >> {bus.mem_addr_lo, 3'b000};
    ld_data = shifted;
    ld_mis  = 1'b0;
    case (bus.mem_funct3)
      3'b000:  ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b001: begin
        ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        ld_mis  = bus.mem_addr_lo[0];
      end
      3'b101: begin
        ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        ld_mis  = bus.mem_addr_lo[0];
      end
      default: ld_mis = (bus.mem_addr_lo != 2'b00);
    endcase
  end

  // x0 writes complete the ALU handshake but are never queued or written
  assign ld_write = bus.mem_valid && !ld_mis && (bus.mem_sel != '0);
  assign alu_take = bus.alu_valid && bus.alu_ready && (bus.alu_sel != '0);
  assign deq      = !ld_write && (count != '0);
  assign bypass   = alu_take && (count == '0) && !ld_write;
  assign enq      = alu_take && !bypass;

  // Survivors are packed toward the head, skipping the dequeued head and any
  // entry the load overwrites; the same-cycle ALU input is younger and goes last.
  always_comb begin
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      n_sel[i]  = '0;
      n_data[i] = '0;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < count) && !(deq && (i == 0)) && !(ld_write && (q_sel[i] == bus.mem_sel))) begin
        n_sel[n[IW-1:0]]  = q_sel[i];
        n_data[n[IW-1:0]] = q_data[i];
        n = n + 1'b1;
      end
    end
    if (enq) begin
      n_sel[n[IW-1:0]]  = bus.alu_sel;
      n_data[n[IW-1:0]] = bus.alu_data;
      n = n + 1'b1;
    end
    n_count = n;
  end

  always_comb begin
    w_en   = 1'b0;
    w_sel  = '0;
    w_data = '0;
    if (ld_write) begin
      w_en   = 1'b1;
      w_sel  = bus.mem_sel;
      w_data = ld_data;
    end else if (count != '0) begin
      w_en   = 1'b1;
      w_sel  = q_sel[0];
      w_data = q_data[0];
    end else if (bypass) begin
      w_en   = 1'b1;
      w_sel  = bus.alu_sel;
      w_data = bus.alu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      bus.wEn        <= 1'b0;
      bus.write_sel  <= '0;
      bus.write_data <= '0;
      bus.misalign   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_sel[i]  <= '0;
        q_data[i] <= '0;
      end
    end else begin
      count          <= n_count;
      bus.wEn        <= w_en;
      bus.write_sel  <= w_sel;
      bus.write_data <= w_data;
      bus.misalign   <= bus.mem_valid && ld_mis;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_sel[i]  <= n_sel[i];
        q_data[i] <= n_data[i];
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - table-driven scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  asel;
    logic [31:0] adata;
    bit          mv;
    logic [4:0]  msel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rd;
    bit          rdy;
    bit          ew;
    logic [4:0]  esel;
    logic [31:0] ed;
    bit          emis;
  } vec_t;

  typedef struct {
    int          idx;
    bit          ew;
    logic [4:0]  esel;
    logic [31:0] ed;
    bit          emis;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  writeback_arbiter_if #(.DATA_WIDTH(32), .SEL_BITS(5)) bus ();

  writeback_arbiter #(.DATA_WIDTH(32), .SEL_BITS(5), .FIFO_DEPTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(bit rst, bit av, logic [4:0] asel, logic [31:0] adata,
                              bit mv, logic [4:0] msel, logic [2:0] f3, logic [1:0] lo,
                              logic [31:0] rd, bit rdy, bit ew, logic [4:0] esel,
                              logic [31:0] ed, bit emis);
    vec_t v;
    v.rst = rst; v.av = av; v.asel = asel; v.adata = adata;
    v.mv = mv; v.msel = msel; v.f3 = f3; v.lo = lo; v.rd = rd;
    v.rdy = rdy; v.ew = ew; v.esel = esel; v.ed = ed; v.emis = emis;
    return v;
  endfunction

  function automatic vec_t idle(bit rdy, bit ew, logic [4:0] esel, logic [31:0] ed);
    return mk(0, 0, 0, 0, 0, 0, LW, 0, 0, rdy, ew, esel, ed, 0);
  endfunction

  // LW load to msel plus an ALU offer in the same cycle; the load is what writes next
  function automatic vec_t ldalu(logic [4:0] msel, logic [31:0] rd, logic [4:0] asel,
                                 logic [31:0] adata, bit av, bit rdy);
    return mk(0, av, asel, adata, 1, msel, LW, 0, rd, rdy, 1, msel, rd, 0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wEn", e.idx, 32'(bus.wEn), 32'(e.ew));
      chk("misalign", e.idx, 32'(bus.misalign), 32'(e.emis));
      if (e.ew) begin
        chk("write_sel", e.idx, 32'(bus.write_sel), 32'(e.esel));
        chk("write_data", e.idx, bus.write_data, e.ed);
      end
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    exp_t e;
    @(negedge clock);
    check_out();
    reset           = t.rst;
    bus.alu_valid   = t.av;
    bus.alu_sel     = t.asel;
    bus.alu_data    = t.adata;
    bus.mem_valid   = t.mv;
    bus.mem_sel     = t.msel;
    bus.mem_funct3  = t.f3;
    bus.mem_addr_lo = t.lo;
    bus.mem_rdata   = t.rd;
    #1;
    chk("alu_ready", idx, 32'(bus.alu_ready), 32'(t.rdy));
    e.idx = idx; e.ew = t.ew; e.esel = t.esel; e.ed = t.ed; e.emis = t.emis;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_sel = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_sel = 0; bus.mem_funct3 = 0; bus.mem_addr_lo = 0; bus.mem_rdata = 0;

    // reset state and plain ALU bypass
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, LW, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 32'h1234, 0, 0, LW, 0, 0, 1, 1, 5, 32'h0000_1234, 0));
    vecs.push_back(idle(1, 0, 0, 0));
    // load alignment, rdata 0x80FF7F01
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, LB,  3, 32'h80FF7F01, 1, 1, 1, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, LBU, 1, 32'h80FF7F01, 1, 1, 2, 32'h0000_007F, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, LH,  2, 32'h80FF7F01, 1, 1, 3, 32'hFFFF_80FF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, LH,  1, 32'h80FF7F01, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, LHU, 2, 32'h80FF7F01, 1, 1, 5, 32'h0000_80FF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, LW,  0, 32'h80FF7F01, 1, 1, 4, 32'h80FF_7F01, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, LW,  2, 32'h80FF7F01, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6, 3'b011, 0, 32'h80FF7F01, 1, 1, 6, 32'h80FF_7F01, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, LW,  0, 32'h80FF7F01, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, LB,  0, 32'h80FF7F01, 1, 1, 7, 32'h0000_0001, 0));
    // contention: load 3 + ALU 4, then ALU 6
    vecs.push_back(ldalu(3, 32'h1111_1111, 4, 32'h44, 1, 1));
    vecs.push_back(mk(0, 1, 6, 32'h66, 0, 0, LW, 0, 0, 1, 1, 4, 32'h44, 0));
    vecs.push_back(idle(1, 1, 6, 32'h66));
    vecs.push_back(idle(1, 0, 0, 0));
    // full FIFO under three load cycles; third ALU offer is refused
    vecs.push_back(ldalu(8,  32'h08, 9,  32'h90, 1, 1));
    vecs.push_back(ldalu(10, 32'h0A, 11, 32'hB0, 1, 1));
    vecs.push_back(ldalu(12, 32'h0C, 13, 32'hD0, 1, 0));
    vecs.push_back(idle(0, 1, 9, 32'h90));
    vecs.push_back(idle(1, 1, 11, 32'hB0));
    vecs.push_back(idle(1, 0, 0, 0));
    // kill: queued x7=0xAA overwritten by load 0xBB
    vecs.push_back(ldalu(1, 32'h01, 7, 32'hAA, 1, 1));
    vecs.push_back(ldalu(7, 32'hBB, 0, 0, 0, 1));
    vecs.push_back(ldalu(2, 32'h02, 20, 32'h20, 1, 1));
    vecs.push_back(ldalu(3, 32'h03, 21, 32'h21, 1, 1));
    vecs.push_back(idle(0, 1, 20, 32'h20));
    vecs.push_back(idle(1, 1, 21, 32'h21));
    vecs.push_back(idle(1, 0, 0, 0));
    // same-cycle ALU to the killed register survives
    vecs.push_back(ldalu(14, 32'h0E, 15, 32'hF5, 1, 1));
    vecs.push_back(ldalu(15, 32'h0F, 15, 32'hF6, 1, 1));
    vecs.push_back(idle(1, 1, 15, 32'hF6));
    vecs.push_back(idle(1, 0, 0, 0));
    // kill of the head with a survivor behind it
    vecs.push_back(ldalu(1, 32'h01, 16, 32'h16, 1, 1));
    vecs.push_back(ldalu(2, 32'h02, 17, 32'h17, 1, 1));
    vecs.push_back(ldalu(16, 32'h99, 0, 0, 0, 0));
    vecs.push_back(idle(1, 1, 17, 32'h17));
    vecs.push_back(idle(1, 0, 0, 0));
    // x0 ALU write
    vecs.push_back(mk(0, 1, 0, 32'hDEAD, 0, 0, LW, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0, 0));
    // reset with two entries queued and an ALU offer in flight
    vecs.push_back(ldalu(1, 32'h01, 22, 32'h22, 1, 1));
    vecs.push_back(ldalu(2, 32'h02, 23, 32'h23, 1, 1));
    vecs.push_back(mk(1, 1, 24, 32'h24, 0, 0, LW, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0, 0));

    repeat (3) @(posedge clock);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // sustained loads starve a queued entry, which drains once they stop
    step(ldalu(1, 32'h01, 25, 32'h25, 1, 1), 100);
    for (int k = 0; k < 5; k++) step(ldalu(2, 32'h200 + 32'(k), 0, 0, 0, 1), 101 + k);
    step(idle(1, 1, 25, 32'h25), 106);
    step(idle(1, 0, 0, 0), 107);

    @(negedge clock);
    check_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback-stage arbiter that drives the single write port (wEn / write_sel / write_data) of the register file. It merges two producers: ALU/CSR results from the execute pipeline, and load responses from the data memory. Load responses are byte/halfword aligned and sign- or zero-extended here. Loads always win the write port; displaced ALU writes wait in a small in-order skid FIFO with ready/valid back-pressure to the execute stage.

## Interface
- DATA_WIDTH, 32, register/data width (load alignment logic is defined for 32)
- SEL_BITS, 5, register select width
- FIFO_DEPTH, 2, ALU skid FIFO entries (power of two, ≥2)

- clock  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered this cycle
- alu_sel  in  SEL_BITS  destination register of ALU result
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- mem_valid  in  1  load response this cycle (no back-pressure; always consumed)
- mem_sel  in  SEL_BITS  load destination register
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- mem_addr_lo  in  2  byte offset of load address
- mem_rdata  in  DATA_WIDTH  raw word from data memory
- wEn  out  1  register file write enable (registered)
- write_sel  out  SEL_BITS  register file write select (registered)
- write_data  out  DATA_WIDTH  register file write data (registered)
- misalign  out  1  one-cycle pulse: load response dropped as misaligned (registered)

## Operation
- Writes to x0 (sel == 0) are discarded at input: an ALU one is accepted (handshake completes) but never enters the FIFO. A load one never produces wEn.
- alu_ready = !reset && (fifo_count < FIFO_DEPTH), a function of state only, independent of this cycle's valids.
- Load alignment: shifted = mem_rdata >> (8*mem_addr_lo).
  - LB / LBU: shifted[7:0], sign- / zero-extended.
  - LH / LHU: shifted[15:0], sign- / zero-extended.
  - LW: full word.
- Misaligned loads produce no write and pulse misalign next cycle:
  - LH/LHU with mem_addr_lo[0] = 1.
  - LW with mem_addr_lo ≠ 0.
- Per-cycle output selection, in priority order:
  - P1: valid, aligned load with mem_sel ≠ 0.
  - P2: FIFO head.
  - P3: accepted ALU input, bypassing the FIFO, only when the FIFO is empty and P1 is absent.
- An accepted ALU input not taken by P3 is enqueued at the tail.
- Dequeue and enqueue in the same cycle are allowed. Count changes by +1, −1 or 0.
- Program order: FIFO entries and the same-cycle ALU input are younger than nothing in flight except a load.
  - Rule: a load write to register R kills every FIFO entry with sel == R. Killed entries are cleared in the same cycle and never written.
  - A same-cycle ALU input with sel == R is younger than the load: it is kept and enqueued.
- Upstream guarantees no younger load to R is outstanding behind an ALU write to R. No check is made for that case.
- Killed entries are compacted out; count decreases by the number killed, plus any dequeue. FIFO order of the survivors is preserved.

## Timing
- Reset (cycle after reset sampled high):
  - wEn = 0, write_sel = 0, write_data = 0, misalign = 0.
  - FIFO empty.
  - alu_ready = 0 while reset is high and 1 in the first cycle after release.
- Reset mid-operation: all FIFO entries and any in-flight input are dropped, with no wEn in the following cycle.
- Latency, accepted input to wEn high: exactly 1 cycle for a load, and for an ALU input taking P3.
- A queued ALU entry writes in the first cycle where no P1 load is present.
- wEn is high for exactly one cycle per write. Back-to-back writes occur on consecutive cycles.
- FIFO full: alu_ready is low the following cycle. It rises the cycle after a dequeue or kill frees an entry.
- Throughput: one register write per cycle.
- Sustained loads starve the FIFO indefinitely. There is no fairness requirement.

## Test plan
- ALU only, FIFO empty: alu_valid, sel=5, data=0x1234 → next cycle wEn=1, write_sel=5, write_data=0x00001234; alu_ready stays 1.
- Load alignment: rdata=0x80FF7F01.
  - LB, addr_lo=3 → write_data 0xFFFFFF80.
  - LBU, addr_lo=1 → 0x0000007F.
  - LH, addr_lo=2 → 0xFFFF80FF.
  - LH, addr_lo=1 → no wEn, misalign=1.
- Contention: load (sel=3) and ALU (sel=4) in the same cycle, then ALU (sel=6) → writes in cycles +1, +2, +3: sel 3, 4, 6.
- Full FIFO: 3 cycles of loads with concurrent ALU writes.
  - alu_ready=0 after 2 ALU entries are queued.
  - Drain order matches entry order once loads stop.
- Kill: FIFO holds sel=7 (old value 0xAA); load to sel=7 with 0xBB → one write of 0xBB to x7; the 0xAA entry is never written; count drops to 0.
- x0 and reset: ALU sel=0 → ready handshake completes, no wEn. Assert reset with 2 entries queued → no wEn in the next cycle, FIFO empty, alu_ready=1 after release.
